// File: rtl/vcm_i2c_pkg.sv
// Shared types and constants for the VCM lens-driver I2C target.
package vcm_i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_BYTE,
        ST_WR_ACK,
        ST_RD_BYTE,
        ST_RD_ACK,
        ST_IGNORE
    } vcm_i2c_state_t;

    localparam logic [7:0] ADDR_WR        = 8'h18;
    localparam logic [7:0] ADDR_RD        = 8'h19;
    localparam int         BYTES_PER_XFER = 2;

    // The only bit that differs between the write and read address bytes is R/W.
    localparam logic [7:0] RW_BIT_MASK = ADDR_WR ^ ADDR_RD;

    // Saturating increment for the NACK event counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/vcm_i2c_slave_line_sync.sv
// Bus-line conditioner: 2-flop synchronizer, optional 3-sample majority
// filter (VCM_I2C_SLAVE_GLITCH_FILT_EN), and single-cycle edge detection.
// Idle level of an I2C line is high, so every flop resets to 1 to avoid a
// phantom edge when reset is released.
module i2c_line_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_line,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic w_level;

    // Two-stage synchronizer for the asynchronous pad input.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_line;
            r_sync2 <= r_sync1;
        end
    end

`ifdef VCM_I2C_SLAVE_GLITCH_FILT_EN
    logic [1:0] r_hist;
    logic       r_filt;

    // Majority of the current and two previous samples; a single-cycle blip never wins.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hist <= 2'b11;
            r_filt <= 1'b1;
        end else begin
            r_hist <= {r_hist[0], r_sync2};
            r_filt <= (r_sync2 & r_hist[0]) | (r_sync2 & r_hist[1]) | (r_hist[0] & r_hist[1]);
        end
    end

    assign w_level = r_filt;
`else
    assign w_level = r_sync2;
`endif

    // Previous level, used to form the edge pulses.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev <= 1'b1;
        end else begin
            r_prev <= w_level;
        end
    end

    assign o_level = w_level;
    assign o_rise  = w_level & ~r_prev;
    assign o_fall  = ~w_level & r_prev;

endmodule

// File: rtl/vcm_i2c_slave.sv
// I2C target modelling the VCM lens-driver position/control register.
// 2-byte writes update VCM_DATA; reads return VCM_DATA hi, lo, hi, ...
// Optional input glitch filter: define VCM_I2C_SLAVE_GLITCH_FILT_EN.
//
// state       | meaning
// ST_IDLE     | bus free or not yet started
// ST_ADDR     | shifting in the address byte
// ST_ADDR_ACK | driving ACK for a matching address
// ST_WR_BYTE  | shifting in a data byte from the master
// ST_WR_ACK   | driving ACK for a received data byte
// ST_RD_BYTE  | shifting a register byte out to the master
// ST_RD_ACK   | sampling the master's ACK/NACK
// ST_IGNORE   | not addressed or refused; wait for START/STOP
module vcm_i2c_slave
    import vcm_i2c_pkg::*;
#(
    parameter logic [6:0]  SLAVE_ADDR7 = 7'h0C,
    parameter logic [15:0] RESET_DATA  = 16'h0000
) (
    input  logic        CLK_50,
    input  logic        RESET_N,
    input  logic        I2C_SCL,
    input  logic        I2C_SDA_IN,
    output logic        SDA_OE,
    output logic [15:0] VCM_DATA,
    output logic        VCM_WR_STB,
    output logic        BUSY,
    output logic [7:0]  NACK_CNT
);

    logic w_scl_lvl, w_scl_rise, w_scl_fall;
    logic w_sda_lvl, w_sda_rise, w_sda_fall;
    logic w_start, w_stop;
    logic [7:0] w_byte_in;

    vcm_i2c_state_t r_state, w_state_nxt;
    logic [3:0]  r_bit_cnt,  w_bit_cnt_nxt;
    logic [6:0]  r_shift,    w_shift_nxt;
    logic        r_rw,       w_rw_nxt;
    logic [1:0]  r_byte_idx, w_byte_idx_nxt;
    logic [7:0]  r_hold_hi,  w_hold_hi_nxt;
    logic [7:0]  r_tx,       w_tx_nxt;
    logic        r_ack_ph,   w_ack_ph_nxt;
    logic        r_sda_oe,   w_sda_oe_nxt;
    logic        r_busy,     w_busy_nxt;
    logic [7:0]  r_nack_cnt, w_nack_cnt_nxt;
    logic [15:0] r_vcm_data, w_vcm_data_nxt;
    logic        r_wr_stb,   w_wr_stb_nxt;

    i2c_line_sync u_scl_sync (
        .i_clk   (CLK_50),
        .i_rst_n (RESET_N),
        .i_line  (I2C_SCL),
        .o_level (w_scl_lvl),
        .o_rise  (w_scl_rise),
        .o_fall  (w_scl_fall)
    );

    i2c_line_sync u_sda_sync (
        .i_clk   (CLK_50),
        .i_rst_n (RESET_N),
        .i_line  (I2C_SDA_IN),
        .o_level (w_sda_lvl),
        .o_rise  (w_sda_rise),
        .o_fall  (w_sda_fall)
    );

    assign w_start   = w_sda_fall & w_scl_lvl;
    assign w_stop    = w_sda_rise & w_scl_lvl;
    assign w_byte_in = {r_shift, w_sda_lvl};

    // State register plus all datapath registers; reset releases SDA immediately.
    always_ff @(posedge CLK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= 4'd0;
            r_shift    <= 7'd0;
            r_rw       <= 1'b0;
            r_byte_idx <= 2'd0;
            r_hold_hi  <= 8'd0;
            r_tx       <= 8'd0;
            r_ack_ph   <= 1'b0;
            r_sda_oe   <= 1'b0;
            r_busy     <= 1'b0;
            r_nack_cnt <= 8'd0;
            r_vcm_data <= RESET_DATA;
            r_wr_stb   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_rw       <= w_rw_nxt;
            r_byte_idx <= w_byte_idx_nxt;
            r_hold_hi  <= w_hold_hi_nxt;
            r_tx       <= w_tx_nxt;
            r_ack_ph   <= w_ack_ph_nxt;
            r_sda_oe   <= w_sda_oe_nxt;
            r_busy     <= w_busy_nxt;
            r_nack_cnt <= w_nack_cnt_nxt;
            r_vcm_data <= w_vcm_data_nxt;
            r_wr_stb   <= w_wr_stb_nxt;
        end
    end

    // Next-state and register updates; STOP outranks START, both outrank bit handling.
    always_comb begin
        w_state_nxt    = r_state;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_shift_nxt    = r_shift;
        w_rw_nxt       = r_rw;
        w_byte_idx_nxt = r_byte_idx;
        w_hold_hi_nxt  = r_hold_hi;
        w_tx_nxt       = r_tx;
        w_ack_ph_nxt   = r_ack_ph;
        w_sda_oe_nxt   = r_sda_oe;
        w_busy_nxt     = r_busy;
        w_nack_cnt_nxt = r_nack_cnt;
        w_vcm_data_nxt = r_vcm_data;
        w_wr_stb_nxt   = 1'b0;

        if (w_stop) begin
            w_state_nxt  = ST_IDLE;
            w_sda_oe_nxt = 1'b0;
            w_busy_nxt   = 1'b0;
        end else if (w_start) begin
            w_state_nxt   = ST_ADDR;
            w_bit_cnt_nxt = 4'd0;
            w_shift_nxt   = 7'd0;
            w_ack_ph_nxt  = 1'b0;
            w_sda_oe_nxt  = 1'b0;
        end else begin
            case (r_state)
                ST_ADDR: begin
                    if (w_scl_rise) begin
                        w_shift_nxt   = w_byte_in[6:0];
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'd7) begin
                            w_bit_cnt_nxt = 4'd0;
                            w_ack_ph_nxt  = 1'b0;
                            if (w_byte_in[7:1] == SLAVE_ADDR7) begin
                                w_state_nxt = ST_ADDR_ACK;
                                w_busy_nxt  = 1'b1;
                                w_rw_nxt    = |(w_byte_in & RW_BIT_MASK);
                            end else begin
                                w_state_nxt    = ST_IGNORE;
                                w_busy_nxt     = 1'b0;
                                w_nack_cnt_nxt = sat_inc8(r_nack_cnt);
                            end
                        end
                    end
                end

                ST_ADDR_ACK: begin
                    if (w_scl_fall) begin
                        if (!r_ack_ph) begin
                            w_sda_oe_nxt = 1'b1;
                            w_ack_ph_nxt = 1'b1;
                        end else begin
                            w_ack_ph_nxt   = 1'b0;
                            w_bit_cnt_nxt  = 4'd0;
                            w_byte_idx_nxt = 2'd0;
                            if (r_rw) begin
                                // The ACK clock's falling edge is also where the first read bit goes out.
                                w_tx_nxt     = r_vcm_data[15:8];
                                w_sda_oe_nxt = ~r_vcm_data[15];
                                w_state_nxt  = ST_RD_BYTE;
                            end else begin
                                w_sda_oe_nxt = 1'b0;
                                w_state_nxt  = ST_WR_BYTE;
                            end
                        end
                    end
                end

                ST_WR_BYTE: begin
                    if (w_scl_rise) begin
                        w_shift_nxt   = w_byte_in[6:0];
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'd7) begin
                            w_bit_cnt_nxt = 4'd0;
                            w_ack_ph_nxt  = 1'b0;
                            if (int'(r_byte_idx) < BYTES_PER_XFER) begin
                                w_state_nxt = ST_WR_ACK;
                                if (int'(r_byte_idx) == BYTES_PER_XFER - 1) begin
                                    w_vcm_data_nxt = {r_hold_hi, w_byte_in};
                                    w_wr_stb_nxt   = 1'b1;
                                end else begin
                                    w_hold_hi_nxt = w_byte_in;
                                end
                            end else begin
                                w_state_nxt    = ST_IGNORE;
                                w_nack_cnt_nxt = sat_inc8(r_nack_cnt);
                            end
                        end
                    end
                end

                ST_WR_ACK: begin
                    if (w_scl_fall) begin
                        if (!r_ack_ph) begin
                            w_sda_oe_nxt = 1'b1;
                            w_ack_ph_nxt = 1'b1;
                        end else begin
                            w_sda_oe_nxt   = 1'b0;
                            w_ack_ph_nxt   = 1'b0;
                            w_bit_cnt_nxt  = 4'd0;
                            w_byte_idx_nxt = r_byte_idx + 2'd1;
                            w_state_nxt    = ST_WR_BYTE;
                        end
                    end
                end

                ST_RD_BYTE: begin
                    if (w_scl_rise) begin
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    end else if (w_scl_fall) begin
                        if (r_bit_cnt == 4'd8) begin
                            w_sda_oe_nxt = 1'b0;
                            w_state_nxt  = ST_RD_ACK;
                        end else begin
                            w_sda_oe_nxt = ~r_tx[3'd7 - r_bit_cnt[2:0]];
                        end
                    end
                end

                ST_RD_ACK: begin
                    if (w_scl_rise) begin
                        if (!w_sda_lvl) begin
                            // Snapshot the register now so each byte is internally coherent.
                            w_tx_nxt       = r_byte_idx[0] ? r_vcm_data[15:8] : r_vcm_data[7:0];
                            w_byte_idx_nxt = {1'b0, ~r_byte_idx[0]};
                            w_bit_cnt_nxt  = 4'd0;
                            w_state_nxt    = ST_RD_BYTE;
                        end else begin
                            w_state_nxt = ST_IGNORE;
                        end
                    end
                end

                ST_IDLE, ST_IGNORE: begin
                    w_sda_oe_nxt = 1'b0;
                end

                default: begin
                    w_state_nxt  = ST_IDLE;
                    w_sda_oe_nxt = 1'b0;
                end
            endcase
        end
    end

    assign SDA_OE     = r_sda_oe;
    assign VCM_DATA   = r_vcm_data;
    assign VCM_WR_STB = r_wr_stb;
    assign BUSY       = r_busy;
    assign NACK_CNT   = r_nack_cnt;

endmodule

// File: tb/tb_vcm_i2c_slave.sv
// Directed bench for vcm_i2c_slave: a bit-banged I2C master with a
// scoreboard of expected ACKs, read bytes and register state.
module tb_vcm_i2c_slave;

    localparam int QTR = 10;

    logic        clk;
    logic        rst_n;
    logic        m_scl;
    logic        m_sda;
    logic        w_bus;
    logic        sda_oe;
    logic [15:0] vcm_data;
    logic        vcm_wr_stb;
    logic        busy;
    logic [7:0]  nack_cnt;

    int          n_pass;
    int          n_total;
    int          stb_cnt;
    string       sb_tag[$];
    logic [15:0] sb_val[$];

    assign w_bus = m_sda & ~sda_oe;

    vcm_i2c_slave dut (
        .CLK_50     (clk),
        .RESET_N    (rst_n),
        .I2C_SCL    (m_scl),
        .I2C_SDA_IN (w_bus),
        .SDA_OE     (sda_oe),
        .VCM_DATA   (vcm_data),
        .VCM_WR_STB (vcm_wr_stb),
        .BUSY       (busy),
        .NACK_CNT   (nack_cnt)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk) begin
        if (vcm_wr_stb) stb_cnt++;
    end

    task automatic q();
        repeat (QTR) @(negedge clk);
    endtask

    task automatic expect_v(input string tag, input logic [15:0] v);
        sb_tag.push_back(tag);
        sb_val.push_back(v);
    endtask

    task automatic observe(input logic [15:0] obs);
        string       tag;
        logic [15:0] exp_v;
        n_total++;
        if (sb_val.size() == 0) begin
            $error("FAIL sb_underflow: observed %h with no expected value queued", obs);
        end else begin
            tag   = sb_tag.pop_front();
            exp_v = sb_val.pop_front();
            assert (obs === exp_v) n_pass++;
            else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic bit_xfer(input logic b, output logic r);
        m_sda = b;
        q();
        m_scl = 1'b1;
        q();
        r = w_bus;
        q();
        m_scl = 1'b0;
        q();
    endtask

    task automatic i2c_start();
        m_sda = 1'b1;
        q();
        m_scl = 1'b1;
        q();
        m_sda = 1'b0;
        q();
        m_scl = 1'b0;
        q();
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0;
        q();
        m_scl = 1'b1;
        q();
        m_sda = 1'b1;
        q();
    endtask

    task automatic wr_byte(input logic [7:0] b, input logic exp_ack, input string tag);
        logic r;
        expect_v(tag, {15'd0, exp_ack});
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], r);
        bit_xfer(1'b1, r);
        observe({15'd0, ~r});
    endtask

    task automatic rd_byte(input logic [7:0] exp_b, input logic m_ack, input string tag);
        logic       r;
        logic [7:0] d;
        expect_v(tag, {8'd0, exp_b});
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, r);
            d[i] = r;
        end
        bit_xfer(~m_ack, r);
        observe({8'd0, d});
    endtask

    task automatic chk(input string tag, input logic [15:0] exp_v, input logic [15:0] obs);
        expect_v(tag, exp_v);
        observe(obs);
    endtask

    initial begin
        logic r;
        n_pass  = 0;
        n_total = 0;
        stb_cnt = 0;
        m_scl   = 1'b1;
        m_sda   = 1'b1;
        rst_n   = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        chk("rst_sda_oe", 16'd0, {15'd0, sda_oe});
        chk("rst_data",   16'h0000, vcm_data);
        chk("rst_busy",   16'd0, {15'd0, busy});
        chk("rst_nack",   16'd0, {8'd0, nack_cnt});
        chk("rst_stb",    16'd0, 16'(stb_cnt));

        // Two-byte write
        i2c_start();
        wr_byte(8'h18, 1'b1, "t1_addr_ack");
        chk("t1_busy_on", 16'd1, {15'd0, busy});
        wr_byte(8'h03, 1'b1, "t1_d0_ack");
        wr_byte(8'hFF, 1'b1, "t1_d1_ack");
        i2c_stop();
        repeat (10) @(negedge clk);
        chk("t1_data",     16'h03FF, vcm_data);
        chk("t1_stb",      16'd1, 16'(stb_cnt));
        chk("t1_busy_off", 16'd0, {15'd0, busy});

        // Read back with master ACK then NACK
        i2c_start();
        wr_byte(8'h19, 1'b1, "t2_addr_ack");
        rd_byte(8'h03, 1'b1, "t2_rd_hi");
        rd_byte(8'hFF, 1'b0, "t2_rd_lo");
        chk("t2_released", 16'd0, {15'd0, sda_oe});
        i2c_stop();
        repeat (10) @(negedge clk);
        chk("t2_busy_off", 16'd0, {15'd0, busy});

        // Foreign address is ignored
        i2c_start();
        wr_byte(8'h1A, 1'b0, "t3_addr_noack");
        wr_byte(8'h77, 1'b0, "t3_ignored");
        chk("t3_busy", 16'd0, {15'd0, busy});
        i2c_stop();
        repeat (10) @(negedge clk);
        chk("t3_nack", 16'd1, {8'd0, nack_cnt});
        chk("t3_data", 16'h03FF, vcm_data);

        // Three data bytes: third is refused
        i2c_start();
        wr_byte(8'h18, 1'b1, "t4_addr_ack");
        wr_byte(8'h12, 1'b1, "t4_d0_ack");
        wr_byte(8'h34, 1'b1, "t4_d1_ack");
        wr_byte(8'h56, 1'b0, "t4_d2_nack");
        i2c_stop();
        repeat (10) @(negedge clk);
        chk("t4_data", 16'h1234, vcm_data);
        chk("t4_nack", 16'd2, {8'd0, nack_cnt});
        chk("t4_stb",  16'd2, 16'(stb_cnt));

        // One data byte, repeated START, then read
        i2c_start();
        wr_byte(8'h18, 1'b1, "t5_waddr_ack");
        wr_byte(8'hAB, 1'b1, "t5_d0_ack");
        i2c_start();
        wr_byte(8'h19, 1'b1, "t5_raddr_ack");
        rd_byte(8'h12, 1'b1, "t5_rd_hi");
        rd_byte(8'h34, 1'b0, "t5_rd_lo");
        i2c_stop();
        repeat (10) @(negedge clk);
        chk("t5_data", 16'h1234, vcm_data);
        chk("t5_stb",  16'd2, 16'(stb_cnt));

        // Reset during the address ACK low phase
        i2c_start();
        for (int i = 7; i >= 0; i--) begin
            logic [7:0] a;
            a = 8'h18;
            bit_xfer(a[i], r);
        end
        chk("t6_ack_driven", 16'd1, {15'd0, sda_oe});
        #3 rst_n = 1'b0;
        #1;
        chk("t6_async_release", 16'd0, {15'd0, sda_oe});
        chk("t6_rst_data", 16'h0000, vcm_data);
        chk("t6_rst_nack", 16'd0, {8'd0, nack_cnt});
        chk("t6_rst_busy", 16'd0, {15'd0, busy});
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        q();
        i2c_stop();
        repeat (10) @(negedge clk);
        i2c_start();
        wr_byte(8'h18, 1'b1, "t6_addr_ack");
        wr_byte(8'h55, 1'b1, "t6_d0_ack");
        wr_byte(8'hAA, 1'b1, "t6_d1_ack");
        i2c_stop();
        repeat (10) @(negedge clk);
        chk("t6_data", 16'h55AA, vcm_data);
        chk("t6_stb",  16'd3, 16'(stb_cnt));
        chk("t6_busy", 16'd0, {15'd0, busy});

        chk("sb_drained", 16'd0, 16'(sb_val.size()));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
